// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================
// Package  : apb_pkg
// Brief    : Shared APB types (requester state, response codes).
// Revision : 1.0
// ============================================================
package apb_pkg;

  typedef enum logic [3:0] {
    MST_IDLE   = 4'b0001,
    MST_SETUP  = 4'b0010,
    MST_ACCESS = 4'b0100,
    MST_RESP   = 4'b1000
  } apb_mst_state_t;

  typedef enum logic [1:0] {
    RSP_OKAY     = 2'b00,
    RSP_SLVERR   = 2'b01,
    RSP_TIMEOUT  = 2'b10,
    RSP_MISALIGN = 2'b11
  } apb_rsp_t;

endpackage
`default_nettype wire

// File: rtl/apb_wait_timer.sv
`default_nettype none
// ============================================================
// Module   : apb_wait_timer
// Brief    : ACCESS-phase wait counter; flags the last allowed wait cycle.
// Revision : 1.0
// ============================================================
module apb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] c_count_last = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign expired = (r_count == c_count_last);

endmodule
`default_nettype wire

// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================
// Module   : apb_master_bridge
// Brief    : Single-outstanding APB4 requester with PREADY timeout and
//            word-alignment checking.
// Revision : 1.0
// ============================================================
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int SW      = DW / 8,
  parameter int TIMEOUT = 16
) (
  input  logic          PCLK,
  input  logic          PRESETn,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  input  logic [SW-1:0] cmd_strb,
  input  logic [2:0]    cmd_prot,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic [1:0]    rsp_code,
  output logic          PSEL,
  output logic          PENABLE,
  output logic          PWRITE,
  output logic [AW-1:0] PADDR,
  output logic [DW-1:0] PWDATA,
  output logic [SW-1:0] PSTRB,
  output logic [2:0]    PPROT,
  output logic          PNSE,
  input  logic [DW-1:0] PRDATA,
  input  logic          PREADY,
  input  logic          PSLVERR
);

  apb_mst_state_t r_state;
  apb_mst_state_t w_state_nxt;

  logic          w_misalign;
  logic          w_expired;
  logic          w_timer_clr;
  logic          w_timer_inc;
  logic          w_cmd_ready;
  logic          w_rsp_valid;
  logic          w_psel;
  logic          w_penable;

  logic [AW-1:0] r_paddr;
  logic          r_pwrite;
  logic [DW-1:0] r_pwdata;
  logic [SW-1:0] r_pstrb;
  logic [2:0]    r_pprot;
  apb_rsp_t      r_rsp_code;
  logic [DW-1:0] r_rsp_rdata;

  assign w_misalign = (cmd_addr[1:0] != 2'b00);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= MST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Control outputs are decoded from the state only, so PREADY and
  // rsp_ready never reach an output combinationally.
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_ready = 1'b0;
    w_rsp_valid = 1'b0;
    w_psel      = 1'b0;
    w_penable   = 1'b0;
    w_timer_clr = 1'b0;
    w_timer_inc = 1'b0;
    unique case (r_state)
      MST_IDLE: begin
        w_cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_state_nxt = w_misalign ? MST_RESP : MST_SETUP;
        end
      end
      MST_SETUP: begin
        w_psel      = 1'b1;
        w_timer_clr = 1'b1;
        w_state_nxt = MST_ACCESS;
      end
      MST_ACCESS: begin
        w_psel      = 1'b1;
        w_penable   = 1'b1;
        w_timer_inc = !PREADY;
        if (PREADY || w_expired) begin
          w_state_nxt = MST_RESP;
        end
      end
      MST_RESP: begin
        w_rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_nxt = MST_IDLE;
        end
      end
      default: begin
        w_state_nxt = MST_IDLE;
      end
    endcase
  end

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .clr     (w_timer_clr),
    .inc     (w_timer_inc),
    .expired (w_expired)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_pstrb     <= '0;
      r_pprot     <= '0;
      r_rsp_code  <= RSP_OKAY;
      r_rsp_rdata <= '0;
    end else begin
      if (r_state == MST_IDLE && cmd_valid) begin
        r_paddr  <= cmd_addr;
        r_pwrite <= cmd_write;
        r_pwdata <= cmd_wdata;
        r_pstrb  <= cmd_write ? cmd_strb : '0;
        r_pprot  <= cmd_prot;
        if (w_misalign) begin
          r_rsp_code  <= RSP_MISALIGN;
          r_rsp_rdata <= '0;
        end
      end
      // PREADY takes priority over an expiring wait counter.
      if (r_state == MST_ACCESS) begin
        if (PREADY) begin
          r_rsp_code  <= PSLVERR ? RSP_SLVERR : RSP_OKAY;
          r_rsp_rdata <= (!r_pwrite && !PSLVERR) ? PRDATA : '0;
        end else if (w_expired) begin
          r_rsp_code  <= RSP_TIMEOUT;
          r_rsp_rdata <= '0;
        end
      end
    end
  end

  assign cmd_ready = w_cmd_ready;
  assign rsp_valid = w_rsp_valid;
  assign rsp_code  = r_rsp_code;
  assign rsp_rdata = r_rsp_rdata;
  assign PSEL      = w_psel;
  assign PENABLE   = w_penable;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign PSTRB     = r_pstrb;
  assign PPROT     = r_pprot;
  assign PNSE      = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ============================================================
// Module   : tb_apb_master_bridge
// Brief    : Scoreboard bench for apb_master_bridge with a configurable slave.
// Revision : 1.0
// ============================================================
module tb_apb_master_bridge;

  localparam int TMO = 16;

  typedef struct packed {
    logic [1:0]  code;
    logic [31:0] rdata;
  } exp_t;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_code;
  logic        PSEL, PENABLE, PWRITE, PNSE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;
  logic        PREADY, PSLVERR;

  int n_vec = 0;
  int n_err = 0;
  exp_t sb_q[$];

  int   slv_waits = 0;
  bit   slv_hang  = 1'b0;
  int   acc_n     = 0;
  int   acc_tot   = 0;
  int   psel_tot  = 0;
  logic [31:0] mon_paddr, mon_pwdata;
  logic [3:0]  mon_pstrb;
  logic [2:0]  mon_pprot;
  logic        mon_pwrite;

  apb_master_bridge #(
    .AW (32), .DW (32), .SW (4), .TIMEOUT (TMO)
  ) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_strb  (cmd_strb),
    .cmd_prot  (cmd_prot),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_code  (rsp_code),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PSTRB     (PSTRB),
    .PPROT     (PPROT),
    .PNSE      (PNSE),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  // Slave model and bus monitor: PREADY is set up on the falling edge for
  // the next rising edge, after slv_waits wait states.
  always @(negedge PCLK) begin
    if (PSEL) psel_tot = psel_tot + 1;
    if (PSEL && PENABLE) begin
      PREADY     = !slv_hang && (acc_n == slv_waits);
      acc_n      = acc_n + 1;
      acc_tot    = acc_tot + 1;
      mon_paddr  = PADDR;
      mon_pwdata = PWDATA;
      mon_pstrb  = PSTRB;
      mon_pprot  = PPROT;
      mon_pwrite = PWRITE;
    end else begin
      PREADY = 1'b0;
      acc_n  = 0;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [2:0] prot, input int waits,
                         input logic [31:0] rdata, input logic err, input bit hang,
                         input logic [1:0] exp_code, input logic [31:0] exp_rdata,
                         input int hold);
    int   lat, acc0, psel0, exp_acc, exp_lat;
    bit   misal, got;
    exp_t e;
    misal = (addr[1:0] != 2'b00);
    if (misal) begin
      exp_acc = 0;        exp_lat = 1;
    end else if (hang) begin
      exp_acc = TMO;      exp_lat = TMO + 2;
    end else begin
      exp_acc = waits + 1; exp_lat = waits + 3;
    end
    slv_waits = waits; slv_hang = hang; PRDATA = rdata; PSLVERR = err;
    sb_q.push_back('{code: exp_code, rdata: exp_rdata});

    @(negedge PCLK);
    check_eq("cmd_ready_idle", {63'd0, cmd_ready}, 64'd1);
    acc0 = acc_tot; psel0 = psel_tot;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
    cmd_wdata = wdata; cmd_strb = strb; cmd_prot = prot;
    @(posedge PCLK);
    lat = 1;
    #1 cmd_valid = 1'b0;

    got = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge PCLK);
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
      @(posedge PCLK);
      lat++;
    end
    e = sb_q.pop_front();
    if (!got) begin
      check_eq("rsp_valid_bound", 64'd0, 64'd1);
      return;
    end

    check_eq("latency", 64'(lat), 64'(exp_lat));
    check_eq("rsp_code", {62'd0, rsp_code}, {62'd0, e.code});
    check_eq("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e.rdata});
    check_eq("cmd_ready_resp", {63'd0, cmd_ready}, 64'd0);
    check_eq("psel_resp", {63'd0, PSEL}, 64'd0);
    check_eq("access_cycles", 64'(acc_tot - acc0), 64'(exp_acc));
    check_eq("psel_cycles", 64'(psel_tot - psel0), misal ? 64'd0 : 64'(exp_acc + 1));
    if (!misal) begin
      check_eq("paddr", {32'd0, mon_paddr}, {32'd0, addr});
      check_eq("pwrite", {63'd0, mon_pwrite}, {63'd0, wr});
      check_eq("pstrb", {60'd0, mon_pstrb}, wr ? {60'd0, strb} : 64'd0);
      check_eq("pprot", {61'd0, mon_pprot}, {61'd0, prot});
      if (wr) check_eq("pwdata", {32'd0, mon_pwdata}, {32'd0, wdata});
    end

    for (int i = 0; i < hold; i++) begin
      @(posedge PCLK);
      @(negedge PCLK);
      check_eq("hold_valid", {63'd0, rsp_valid}, 64'd1);
      check_eq("hold_code", {62'd0, rsp_code}, {62'd0, e.code});
      check_eq("hold_rdata", {32'd0, rsp_rdata}, {32'd0, e.rdata});
      check_eq("hold_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge PCLK);
    #1 rsp_ready = 1'b0;
    @(negedge PCLK);
    check_eq("rsp_valid_drop", {63'd0, rsp_valid}, 64'd0);
    check_eq("cmd_ready_back", {63'd0, cmd_ready}, 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rd, wd;
    int          rw;
    bit          rwr;
    PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0; rsp_ready = 1'b0;
    PRDATA = '0; PSLVERR = 1'b0;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check_eq("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check_eq("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check_eq("rst_psel_pen", {62'd0, PSEL, PENABLE}, 64'd0);
    check_eq("rst_pwrite_pnse", {62'd0, PWRITE, PNSE}, 64'd0);
    check_eq("rst_paddr_pwdata", {PADDR, PWDATA}, 64'd0);
    check_eq("rst_pstrb_pprot", {57'd0, PSTRB, PPROT}, 64'd0);
    check_eq("rst_rsp", {30'd0, rsp_code, rsp_rdata}, 64'd0);
    PRESETn = 1'b1;

    //      wr    addr          wdata         strb  prot  wt  rdata         err   hang  code   rdata         hold
    run_cmd(1'b1, 32'h4000_1004, 32'h0000_002A, 4'hF, 3'd0, 0, 32'h0,        1'b0, 1'b0, 2'b00, 32'h0,        0);
    run_cmd(1'b0, 32'h4000_100C, 32'h5555_5555, 4'hF, 3'd1, 1, 32'hA735_0001, 1'b0, 1'b0, 2'b00, 32'hA735_0001, 0);
    run_cmd(1'b1, 32'h0000_4000, 32'h1234_5678, 4'h3, 3'd2, 0, 32'h0,        1'b1, 1'b0, 2'b01, 32'h0,        0);
    run_cmd(1'b0, 32'h4000_2000, 32'h0,        4'h0, 3'd0, 0, 32'hFFFF_FFFF, 1'b0, 1'b1, 2'b10, 32'h0,        0);
    run_cmd(1'b0, 32'h4000_2004, 32'h0,        4'h0, 3'd0, 0, 32'h1234_5678, 1'b0, 1'b0, 2'b00, 32'h1234_5678, 0);
    run_cmd(1'b1, 32'h4000_1002, 32'h0000_00FF, 4'hF, 3'd0, 0, 32'h0,        1'b0, 1'b0, 2'b11, 32'h0,        0);
    run_cmd(1'b0, 32'h4000_3000, 32'h0,        4'h0, 3'd5, TMO - 1, 32'hCAFE_F00D, 1'b0, 1'b0, 2'b00, 32'hCAFE_F00D, 0);
    run_cmd(1'b0, 32'h4000_3004, 32'h0,        4'h0, 3'd0, 2, 32'h9999_0000, 1'b1, 1'b0, 2'b01, 32'h0,        5);
    run_cmd(1'b0, 32'h4000_3008, 32'h0,        4'h0, 3'd7, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, 2'b00, 32'hDEAD_BEEF, 5);

    // Reset pulse while a read is stuck in ACCESS.
    slv_hang = 1'b1; slv_waits = 0;
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4000_0010;
    @(posedge PCLK);
    #1 cmd_valid = 1'b0;
    repeat (3) @(posedge PCLK);
    #2;
    check_eq("pre_rst_access", {62'd0, PSEL, PENABLE}, 64'd3);
    PRESETn = 1'b0;
    #1;
    check_eq("async_rst_psel_pen", {62'd0, PSEL, PENABLE}, 64'd0);
    check_eq("async_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    slv_hang = 1'b0;
    @(negedge PCLK);
    check_eq("post_rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check_eq("post_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    run_cmd(1'b1, 32'h4000_0020, 32'hA5A5_5A5A, 4'h9, 3'd3, 1, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 0);

    for (int k = 0; k < 6; k++) begin
      rwr = 1'($urandom_range(0, 1));
      rw  = int'($urandom_range(0, 4));
      ra  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      rd  = $urandom;
      wd  = $urandom;
      run_cmd(rwr, ra, wd, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), rw, rd,
              1'b0, 1'b0, 2'b00, rwr ? 32'h0 : rd, k % 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
